msgpass_rqst_addr_gen: RTL and testbench

- Read-address sequencer for the message-pass buffer, Port A. It sits directly upstream of memShare_control_wrapper.
- It sweeps buffer addresses so that each buffer read word becomes the request vector rqst_addr_i of the memShare control.
- When the memShare control flags a decomposed request (is_drc), the block replays that entry, so the second access phase sees the same data.
- It replaces the dummy address generator used in block-level simulation.

---
 rtl/msgpass_rqst_addr_gen.sv | 207 ++++++++++++++++++++
 tb/tb_msgpass_rqst_addr_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/msgpass_rqst_addr_gen.sv
// Msgpass Port A read-address sequencer with DRC replay; perf counters under MSGPASS_ADDR_GEN_PERF_CNT_EN.
// Latency: start->issue 1 cycle, issue->rqst_valid_o READ_LATENCY cycles; no backpressure, is_drc_i forces a replay.
module msgpass_rqst_addr_gen #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DRC_NUM      = 1,
    parameter int READ_LATENCY = 1
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] end_addr_i,
    input  logic [DRC_NUM-1:0]    is_drc_i,
    output logic [ADDR_WIDTH-1:0] raddr_o,
    output logic                  cen_o,
    output logic                  rqst_valid_o,
    output logic                  rqst_replay_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef MSGPASS_ADDR_GEN_PERF_CNT_EN
    ,
    output logic [15:0]           perf_issue_cnt_o,
    output logic [15:0]           perf_replay_cnt_o,
    output logic [15:0]           perf_squash_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [ADDR_WIDTH-1:0] base_q, end_q;
    logic                  cen_q, cen_d;
    logic                  rpl_q, rpl_d;
    logic                  stop_pend_q, stop_pend_d;
    logic [2:0]            drain_cnt_q, drain_cnt_d;

    logic                  tag_vld_q  [READ_LATENCY];
    logic                  tag_rpl_q  [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] tag_addr_q [READ_LATENCY];

    logic start_acc, stop_now, at_end, drain_last, replay_trig;

    assign start_acc   = (state_q == IDLE) && start_i;
    assign stop_now    = stop_pend_q | stop_i;
    assign at_end      = (raddr_q == end_q);
    assign drain_last  = (drain_cnt_q == 3'(READ_LATENCY));
    assign replay_trig = ((state_q == READ) || (state_q == DRAIN)) &&
                         tag_vld_q[READ_LATENCY-1] && !tag_rpl_q[READ_LATENCY-1] && (|is_drc_i);

    assign raddr_o       = raddr_q;
    assign cen_o         = cen_q;
    assign rqst_valid_o  = tag_vld_q[READ_LATENCY-1];
    assign rqst_replay_o = tag_rpl_q[READ_LATENCY-1];

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = READ;
            READ:    if (!replay_trig && at_end && stop_now) state_d = DRAIN;
            DRAIN: begin
                if (replay_trig)     state_d = READ;
                else if (drain_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != IDLE);
        done_o = (state_q == DRAIN) && drain_last;
    end

    // A replay reissues the output tag's address; the normal advance rule then resumes from it.
    always_comb begin
        raddr_d     = raddr_q;
        cen_d       = cen_q;
        rpl_d       = 1'b0;
        stop_pend_d = stop_pend_q;
        drain_cnt_d = '0;
        case (state_q)
            IDLE: begin
                cen_d       = 1'b0;
                stop_pend_d = 1'b0;
                if (start_i) begin
                    raddr_d = base_addr_i;
                    cen_d   = 1'b1;
                end
            end
            READ: begin
                stop_pend_d = stop_now;
                cen_d       = 1'b1;
                if (replay_trig) begin
                    raddr_d = tag_addr_q[READ_LATENCY-1];
                    rpl_d   = 1'b1;
                end else if (at_end) begin
                    if (stop_now) cen_d = 1'b0;
                    else          raddr_d = base_q;
                end else begin
                    raddr_d = raddr_q + 1'b1;
                end
            end
            DRAIN: begin
                cen_d       = 1'b0;
                drain_cnt_d = drain_cnt_q + 3'd1;
                if (replay_trig) begin
                    raddr_d     = tag_addr_q[READ_LATENCY-1];
                    cen_d       = 1'b1;
                    rpl_d       = 1'b1;
                    drain_cnt_d = '0;
                end else if (drain_last) begin
                    stop_pend_d = 1'b0;
                end
            end
            default: cen_d = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            raddr_q     <= '0;
            cen_q       <= 1'b0;
            rpl_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            drain_cnt_q <= '0;
            base_q      <= '0;
            end_q       <= '0;
        end else begin
            raddr_q     <= raddr_d;
            cen_q       <= cen_d;
            rpl_q       <= rpl_d;
            stop_pend_q <= stop_pend_d;
            drain_cnt_q <= drain_cnt_d;
            if (start_acc) begin
                base_q <= base_addr_i;
                end_q  <= end_addr_i;
            end
        end
    end

    // On a replay trigger every younger tag, including this cycle's issue, is squashed.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                tag_vld_q[k]  <= 1'b0;
                tag_rpl_q[k]  <= 1'b0;
                tag_addr_q[k] <= '0;
            end
        end else begin
            tag_vld_q[0]  <= cen_q & ~replay_trig;
            tag_rpl_q[0]  <= rpl_q;
            tag_addr_q[0] <= raddr_q;
            for (int k = 1; k < READ_LATENCY; k++) begin
                tag_vld_q[k]  <= tag_vld_q[k-1] & ~replay_trig;
                tag_rpl_q[k]  <= tag_rpl_q[k-1];
                tag_addr_q[k] <= tag_addr_q[k-1];
            end
        end
    end

`ifdef MSGPASS_ADDR_GEN_PERF_CNT_EN
    logic [15:0] issue_cnt_q, replay_cnt_q, squash_cnt_q;
    logic [2:0]  squash_n;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {14'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        squash_n = '0;
        if (replay_trig) begin
            squash_n = {2'b0, cen_q};
            for (int k = 0; k < READ_LATENCY - 1; k++) begin
                squash_n = squash_n + {2'b0, tag_vld_q[k]};
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst || start_acc) begin
            issue_cnt_q  <= '0;
            replay_cnt_q <= '0;
            squash_cnt_q <= '0;
        end else begin
            issue_cnt_q  <= sat_add(issue_cnt_q, {2'b0, cen_q});
            replay_cnt_q <= sat_add(replay_cnt_q, {2'b0, replay_trig});
            squash_cnt_q <= sat_add(squash_cnt_q, squash_n);
        end
    end

    assign perf_issue_cnt_o  = issue_cnt_q;
    assign perf_replay_cnt_o = replay_cnt_q;
    assign perf_squash_cnt_o = squash_cnt_q;
`endif

endmodule

// File: tb/tb_msgpass_rqst_addr_gen.sv
// Directed bench for msgpass_rqst_addr_gen: READ_LATENCY=1 and READ_LATENCY=3 instances on shared stimulus.
// Each scenario is a per-cycle table of inputs and hand-derived outputs.
module tb_msgpass_rqst_addr_gen;

    typedef int row_t [17];

    logic       clk = 1'b0;
    logic       rst, start, stop;
    logic [3:0] base_a, end_a;
    logic [0:0] drc;
    logic       sel3;

    logic [3:0] ra1, ra3;
    logic       ce1, ce3, vl1, vl3, rp1, rp3, by1, by3, dn1, dn3;
    logic [3:0] o_ra;
    logic       o_ce, o_vl, o_rp, o_by, o_dn;

    int n_chk = 0;
    int n_err = 0;

`ifdef MSGPASS_ADDR_GEN_PERF_CNT_EN
    logic [15:0] pi1, pr1, ps1, pi3, pr3, ps3;
`endif

    always #5 clk = ~clk;

    msgpass_rqst_addr_gen #(.ADDR_WIDTH(4), .DRC_NUM(1), .READ_LATENCY(1)) u_dut1 (
        .sys_clk(clk), .rst(rst), .start_i(start), .stop_i(stop),
        .base_addr_i(base_a), .end_addr_i(end_a), .is_drc_i(drc),
        .raddr_o(ra1), .cen_o(ce1), .rqst_valid_o(vl1), .rqst_replay_o(rp1),
        .busy_o(by1), .done_o(dn1)
`ifdef MSGPASS_ADDR_GEN_PERF_CNT_EN
        , .perf_issue_cnt_o(pi1), .perf_replay_cnt_o(pr1), .perf_squash_cnt_o(ps1)
`endif
    );

    msgpass_rqst_addr_gen #(.ADDR_WIDTH(4), .DRC_NUM(1), .READ_LATENCY(3)) u_dut3 (
        .sys_clk(clk), .rst(rst), .start_i(start), .stop_i(stop),
        .base_addr_i(base_a), .end_addr_i(end_a), .is_drc_i(drc),
        .raddr_o(ra3), .cen_o(ce3), .rqst_valid_o(vl3), .rqst_replay_o(rp3),
        .busy_o(by3), .done_o(dn3)
`ifdef MSGPASS_ADDR_GEN_PERF_CNT_EN
        , .perf_issue_cnt_o(pi3), .perf_replay_cnt_o(pr3), .perf_squash_cnt_o(ps3)
`endif
    );

    always_comb begin
        o_ra = sel3 ? ra3 : ra1;
        o_ce = sel3 ? ce3 : ce1;
        o_vl = sel3 ? vl3 : vl1;
        o_rp = sel3 ? rp3 : rp1;
        o_by = sel3 ? by3 : by1;
        o_dn = sel3 ? dn3 : dn1;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, ".raddr"}, int'(o_ra), 0);
        check_val({tag, ".cen"},   int'(o_ce), 0);
        check_val({tag, ".vld"},   int'(o_vl), 0);
        check_val({tag, ".rpl"},   int'(o_rp), 0);
        check_val({tag, ".busy"},  int'(o_by), 0);
        check_val({tag, ".done"},  int'(o_dn), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; drc = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    // Row k holds the outputs seen in cycle k after start, and the inputs driven during that cycle.
    task automatic run_scn(input string tag, input logic s3, input logic [3:0] b, input logic [3:0] e,
                           input int n, input row_t ra, input row_t ce, input row_t vl, input row_t rp,
                           input row_t dn, input row_t by, input row_t st, input row_t sp, input row_t dr);
        do_reset();
        sel3 = s3;
        check_idle({tag, ".rst"});
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_val({tag, ".idle_stop_busy"}, int'(o_by), 0);
        base_a = b; end_a = e; start = 1'b1;
        tick();
        start = 1'b0;
        base_a = b ^ 4'h5; end_a = e ^ 4'h5;
        for (int k = 1; k <= n; k++) begin
            if (ce[k] != 0) check_val($sformatf("%s.k%0d.raddr", tag, k), int'(o_ra), ra[k]);
            check_val($sformatf("%s.k%0d.cen", tag, k),  int'(o_ce), ce[k]);
            check_val($sformatf("%s.k%0d.vld", tag, k),  int'(o_vl), vl[k]);
            check_val($sformatf("%s.k%0d.rpl", tag, k),  int'(o_rp), rp[k]);
            check_val($sformatf("%s.k%0d.done", tag, k), int'(o_dn), dn[k]);
            check_val($sformatf("%s.k%0d.busy", tag, k), int'(o_by), by[k]);
            start = st[k][0];
            stop  = sp[k][0];
            drc   = dr[k][0];
            if (k < n) tick();
        end
        start = 1'b0; stop = 1'b0; drc = 1'b0;
    endtask

    row_t z = '{default: 0};

    // RL=1, base 0..4, stop during issue of 3, start pulsed while busy
    row_t a_ra = '{0, 0,1,2,3,4, 0,0,0, 0,0,0,0,0,0,0,0};
    row_t a_ce = '{0, 1,1,1,1,1, 0,0,0, 0,0,0,0,0,0,0,0};
    row_t a_vl = '{0, 0,1,1,1,1, 1,0,0, 0,0,0,0,0,0,0,0};
    row_t a_dn = '{0, 0,0,0,0,0, 0,1,0, 0,0,0,0,0,0,0,0};
    row_t a_by = '{0, 1,1,1,1,1, 1,1,0, 0,0,0,0,0,0,0,0};
    row_t a_st = '{0, 0,1,0,0,0, 0,0,0, 0,0,0,0,0,0,0,0};
    row_t a_sp = '{0, 0,0,0,1,0, 0,0,0, 0,0,0,0,0,0,0,0};

    // RL=1, DRC on word 2; is_drc_i held over the squashed and replayed words
    row_t b_ra = '{0, 0,1,2,3,2,3,4, 0,0,0, 0,0,0,0,0,0};
    row_t b_ce = '{0, 1,1,1,1,1,1,1, 0,0,0, 0,0,0,0,0,0};
    row_t b_vl = '{0, 0,1,1,1,0,1,1, 1,0,0, 0,0,0,0,0,0};
    row_t b_rp = '{0, 0,0,0,0,0,1,0, 0,0,0, 0,0,0,0,0,0};
    row_t b_dn = '{0, 0,0,0,0,0,0,0, 0,1,0, 0,0,0,0,0,0};
    row_t b_by = '{0, 1,1,1,1,1,1,1, 1,1,0, 0,0,0,0,0,0};
    row_t b_sp = '{0, 0,0,0,0,0,0,1, 0,0,0, 0,0,0,0,0,0};
    row_t b_dr = '{0, 0,0,0,1,1,1,0, 0,0,0, 0,0,0,0,0,0};

    // RL=3, base 1..3, DRC on word 1 in READ, then DRC on word 3 during DRAIN
    row_t c_ra = '{0, 1,2,3,1,1,2,3, 0,0,0, 3, 0,0,0,0,0};
    row_t c_ce = '{0, 1,1,1,1,1,1,1, 0,0,0, 1, 0,0,0,0,0};
    row_t c_vl = '{0, 0,0,0,1,0,0,0, 1,1,1, 0, 0,0,1,0,0};
    row_t c_rp = '{0, 0,0,0,0,0,0,0, 1,0,0, 0, 0,0,1,0,0};
    row_t c_dn = '{0, 0,0,0,0,0,0,0, 0,0,0, 0, 0,0,0,1,0};
    row_t c_by = '{0, 1,1,1,1,1,1,1, 1,1,1, 1, 1,1,1,1,0};
    row_t c_sp = '{0, 0,0,0,0,0,0,1, 0,0,0, 0, 0,0,0,0,0};
    row_t c_dr = '{0, 0,0,0,1,1,1,1, 1,0,1, 0, 0,0,0,0,0};

    // RL=1, base 14 > end 1, natural wrap through 15->0
    row_t d_ra = '{0, 14,15,0,1,14,15,0,1, 0,0,0, 0,0,0,0,0};
    row_t d_ce = '{0, 1,1,1,1,1,1,1,1, 0,0,0, 0,0,0,0,0};
    row_t d_vl = '{0, 0,1,1,1,1,1,1,1, 1,0,0, 0,0,0,0,0};
    row_t d_dn = '{0, 0,0,0,0,0,0,0,0, 0,1,0, 0,0,0,0,0};
    row_t d_by = '{0, 1,1,1,1,1,1,1,1, 1,1,0, 0,0,0,0,0};
    row_t d_sp = '{0, 0,0,0,0,0,0,0,1, 0,0,0, 0,0,0,0,0};

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; drc = 1'b0;
        base_a = '0; end_a = '0; sel3 = 1'b0;

        run_scn("A", 1'b0, 4'd0, 4'd4, 8, a_ra, a_ce, a_vl, z, a_dn, a_by, a_st, a_sp, z);
        run_scn("B", 1'b0, 4'd0, 4'd4, 10, b_ra, b_ce, b_vl, b_rp, b_dn, b_by, z, b_sp, b_dr);
`ifdef MSGPASS_ADDR_GEN_PERF_CNT_EN
        check_val("B.perf_issue",  int'(pi1), 7);
        check_val("B.perf_replay", int'(pr1), 1);
        check_val("B.perf_squash", int'(ps1), 1);
`endif
        run_scn("C", 1'b1, 4'd1, 4'd3, 16, c_ra, c_ce, c_vl, c_rp, c_dn, c_by, z, c_sp, c_dr);
`ifdef MSGPASS_ADDR_GEN_PERF_CNT_EN
        check_val("C.perf_issue",  int'(pi3), 8);
        check_val("C.perf_replay", int'(pr3), 2);
        check_val("C.perf_squash", int'(ps3), 3);
`endif
        run_scn("D", 1'b0, 4'd14, 4'd1, 11, d_ra, d_ce, d_vl, z, d_dn, d_by, z, d_sp, z);

        // Reset mid-READ at address 3, then restart from base
        do_reset();
        sel3 = 1'b0;
        base_a = 4'd2; end_a = 4'd7; start = 1'b1;
        tick();
        start = 1'b0;
        check_val("E.k1.raddr", int'(o_ra), 2);
        tick();
        check_val("E.k2.raddr", int'(o_ra), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("E.rst");
        tick();
        check_val("E.post.done", int'(o_dn), 0);
        check_val("E.post.busy", int'(o_by), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("E.re.raddr", int'(o_ra), 2);
        check_val("E.re.cen",   int'(o_ce), 1);
        check_val("E.re.vld",   int'(o_vl), 0);
        tick();
        check_val("E.re2.raddr", int'(o_ra), 3);
        check_val("E.re2.vld",   int'(o_vl), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
